pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline. It sequences the PC, IF/ID, ID/EX and EX/MEM state registers.
- Detects load-use hazards and inserts one bubble.
- Converts an EX-stage branch-taken into a synchronous, multi-cycle flush, replacing the asynchronous br_taken clear on the ID/EX register.
- Freezes the whole pipe while data memory is busy, with a timeout monitor.

Parameters:
BR_PENALTY, 1, number of consecutive cycles IF/ID and ID/EX are flushed after a taken branch (legal range 1..15).
MEM_TIMEOUT, 64, consecutive mem_busy cycles after which mem_timeout sets (legal range 2..255).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_ex_memread  in  1  instruction in EX is a load
id_ex_rt  in  5  destination rt of the instruction in EX
if_id_rs  in  5  rs field of the instruction in ID
if_id_rt  in  5  rt field of the instruction in ID
if_id_uses_rt  in  1  instruction in ID reads rt (R-type, beq, sw)
br_taken  in  1  branch resolved taken in EX; level, one cycle per branch
mem_busy  in  1  data memory not ready; the MEM stage must hold
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID synchronous clear
id_ex_bubble  out  1  ID/EX loads all-zero control (nop)
id_ex_hold  out  1  ID/EX keeps its current contents
ex_mem_hold  out  1  EX/MEM keeps its current contents
mem_timeout  out  1  sticky error flag
ctrl_state  out  2  current FSM state: 0 RUN, 1 FLUSH, 2 MEM_WAIT

Behaviour:
- FSM states are RUN, FLUSH and MEM_WAIT. The state register and counters update on the clk rising edge. Outputs are combinational from state and inputs, so there is zero-cycle response within the same cycle.
- Load-use hazard lu = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt))).
- Priority within a cycle: reset > mem_busy > br_taken > lu.
- Reset (while high):
  - Outputs forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, id_ex_hold=0, ex_mem_hold=0.
  - On the next edge: state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0.
- Default in RUN with no event: pc_write=1, if_id_write=1; all other outputs 0.
- mem_busy=1 (in any state):
  - pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, flush=0, bubble=0.
  - Next state is MEM_WAIT.
  - wait_cnt increments and saturates at MEM_TIMEOUT.
  - mem_timeout sets on the edge where wait_cnt reaches MEM_TIMEOUT-1 with mem_busy still 1. It then stays set until reset.
  - If mem_busy rises while in FLUSH, the remaining flush_cnt is preserved and flushing resumes after the wait.
- MEM_WAIT exit: in the cycle mem_busy=0, the block behaves as RUN/FLUSH (restoring the preserved context) and evaluates br_taken and lu normally. wait_cnt clears on that edge.
- br_taken=1 with mem_busy=0:
  - pc_write=1 (branch target loads), if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - If BR_PENALTY>1: next state FLUSH, flush_cnt=BR_PENALTY-1. Otherwise stay in RUN.
  - lu is ignored in that cycle.
- FLUSH:
  - Outputs are the same as the br_taken cycle.
  - flush_cnt decrements each cycle; the block returns to RUN on the edge where flush_cnt goes 1→0.
  - A new br_taken in FLUSH reloads flush_cnt=BR_PENALTY-1.
  - lu is ignored throughout FLUSH.
- lu=1 in RUN with no higher-priority event: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle. There is no state change; the bubble itself clears id_ex_memread on the next cycle.
- Simultaneous br_taken+lu: br_taken wins. Simultaneous mem_busy+br_taken: the branch is held in EX (ex_mem_hold) and is taken in the first cycle after mem_busy falls.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, the block adds three 32-bit saturating output ports, all cleared by reset:
  - stall_cycles: counts lu bubble cycles.
  - flush_cycles: counts cycles with if_id_flush=1 and reset low.
  - wait_cycles: counts cycles with mem_busy=1.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset high 2 cycles, then low, all inputs 0 → during reset if_id_flush=1, id_ex_bubble=1, pc_write=0. Then pc_write=1, if_id_write=1, ctrl_state=0.
- id_ex_memread=1, id_ex_rt=5, if_id_rs=5 for 1 cycle → pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle only. Same stimulus with id_ex_rt=0 → no stall. Same stimulus with if_id_rt=5, if_id_uses_rt=0 → no stall.
- BR_PENALTY=3, single-cycle br_taken pulse → if_id_flush=1 and id_ex_bubble=1 for exactly 3 cycles, ctrl_state=1 for 2 cycles, then RUN. A second br_taken in the 2nd flush cycle extends the flush to 4 total cycles.
- mem_busy=1 for 5 cycles with br_taken=1 held → all holds asserted, no flush for 5 cycles. In cycle 6 (mem_busy=0), if_id_flush=1.
- MEM_TIMEOUT=4, mem_busy=1 for 6 cycles → mem_timeout rises after the 4th busy cycle. It stays 1 after mem_busy drops and clears only on reset.
- Reset asserted mid-FLUSH (BR_PENALTY=5, 2nd cycle) → next cycle ctrl_state=0, no residual flush. With HAZARD_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: load-use bubbles, multi-cycle branch
// flush, and memory-wait freeze with timeout. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        if_id_uses_rt,
  input  logic        br_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_hold,
  output logic        ex_mem_hold,
  output logic        mem_timeout,
  output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
  output logic [31:0] wait_cycles
`endif
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } state_e;

  localparam logic [3:0] FlushReload = 4'(BR_PENALTY - 1);
  localparam logic [7:0] WaitMax     = 8'(MEM_TIMEOUT);
  localparam logic [7:0] WaitLast    = 8'(MEM_TIMEOUT - 1);
  localparam state_e     BrNext      = (BR_PENALTY > 1) ? StFlush : StRun;

  state_e     state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       lu;
  logic       flush_active;

  assign lu = id_ex_memread & (id_ex_rt != 5'd0) &
              ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

  // A memory wait entered mid-flush keeps flush_cnt; a nonzero count resumes the flush.
  assign flush_active = (state_q == StFlush) |
                        ((state_q == StMemWait) & (flush_cnt_q != 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      flush_cnt_q <= 4'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    if (mem_busy) begin
      state_d = StMemWait;
      if (wait_cnt_q != WaitMax) wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_q >= WaitLast) timeout_d = 1'b1;
    end else begin
      wait_cnt_d = 8'd0;
      if (br_taken) begin
        flush_cnt_d = FlushReload;
        state_d     = BrNext;
      end else if (flush_active) begin
        flush_cnt_d = flush_cnt_q - 4'd1;
        state_d     = (flush_cnt_q == 4'd1) ? StRun : StFlush;
      end else begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      id_ex_hold  = 1'b1;
      ex_mem_hold = 1'b1;
    end else if (br_taken || flush_active) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      id_ex_bubble = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  assign mem_timeout = timeout_q;
  assign ctrl_state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_ev;
  assign stall_ev = lu & ~mem_busy & ~br_taken & ~flush_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
      wait_cycles  <= 32'd0;
    end else begin
      if (stall_ev && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush && flush_cycles != '1) flush_cycles <= flush_cycles + 32'd1;
      if (mem_busy && wait_cycles != '1) wait_cycles <= wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (BR_PENALTY=3, MEM_TIMEOUT=4): cycle model compared every
// cycle plus directed literal checks.
module tb_pipe_hazard_ctrl;
  localparam int BP = 3;
  localparam int MT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_ex_memread = 1'b0;
  logic [4:0] id_ex_rt = '0, if_id_rs = '0, if_id_rt = '0;
  logic       if_id_uses_rt = 1'b0, br_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold;
  logic       mem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles, wait_cycles;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.BR_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
    .ex_mem_hold(ex_mem_hold), .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles), .wait_cycles(wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Model: pending = flush cycles still owed after this one; streak = consecutive busy cycles.
  int         m_pend = 0;
  int         m_streak = 0;
  bit         m_to = 1'b0;
  int         m_st = 0;
  bit         m_valid = 1'b0;

  function automatic bit load_use();
    return id_ex_memread && id_ex_rt != 0 &&
           (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
  endfunction

  function automatic int next_pend();
    if (br_taken) return BP - 1;
    if (m_pend > 0) return m_pend - 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b1;
      m_pend   <= 0;
      m_streak <= 0;
      m_to     <= 1'b0;
      m_st     <= 0;
    end else if (mem_busy) begin
      m_streak <= m_streak + 1;
      m_to     <= m_to || (m_streak + 1 >= MT);
      m_st     <= 2;
    end else begin
      m_streak <= 0;
      m_pend   <= next_pend();
      m_st     <= (next_pend() > 0) ? 1 : 0;
    end
  end

  // Expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold}
  function automatic logic [5:0] exp_ctl();
    if (reset) return 6'b001100;
    if (mem_busy) return 6'b000011;
    if (br_taken || m_pend > 0) return 6'b111100;
    if (load_use()) return 6'b000100;
    return 6'b110000;
  endfunction

  always @(negedge clk) begin
    logic [5:0] act, exp;
    act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold};
    exp = exp_ctl();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL ctl_outputs t=%0t actual=%b required=%b", $time, act, exp);
    end
    if (m_valid) begin
      n_cmp++;
      if (ctrl_state !== 2'(m_st) || mem_timeout !== m_to) begin
        n_fail++;
        $display("FAIL state_timeout t=%0t actual=%0d/%b required=%0d/%b", $time,
                 ctrl_state, mem_timeout, m_st, m_to);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br, input logic mb);
    id_ex_memread = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
    if_id_uses_rt = urt; br_taken = br; mem_busy = mb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] efl;
    int         est[5];

    // Reset, two cycles
    @(negedge clk);
    chk("rst_flush", if_id_flush, 1);
    chk("rst_bubble", id_ex_bubble, 1);
    chk("rst_pc_write", pc_write, 0);
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("run_pc_write", pc_write, 1);
    chk("run_if_id_write", if_id_write, 1);
    chk("run_state", ctrl_state, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_init", int'(stall_cycles | flush_cycles | wait_cycles), 0);
`endif
    tick();

    // Load-use variants
    drive(1, 5, 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_bubble", id_ex_bubble, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_one_cycle", id_ex_bubble, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lu_rt_zero", pc_write, 1);
    tick();
    drive(1, 5, 3, 5, 0, 0, 0);
    @(negedge clk);
    chk("lu_rt_unused", pc_write, 1);
    tick();
    drive(1, 5, 3, 5, 1, 0, 0);
    @(negedge clk);
    chk("lu_rt_used", pc_write, 0);
    tick();
    drive(1, 5, 5, 0, 0, 1, 0);
    @(negedge clk);
    chk("br_beats_lu", pc_write, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Single branch: three flush cycles, FLUSH state for two
    efl = 5'b00111; est = '{0, 1, 1, 0, 0};
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("br1_flush_%0d", i), if_id_flush, int'(efl[i]));
      chk($sformatf("br1_state_%0d", i), ctrl_state, est[i]);
      tick();
      br_taken = 1'b0;
    end

    // Second branch in 2nd flush cycle extends flush to four
    efl = 5'b01111; est = '{0, 1, 1, 1, 0};
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("br2_flush_%0d", i), if_id_flush, int'(efl[i]));
      chk($sformatf("br2_state_%0d", i), ctrl_state, est[i]);
      tick();
      br_taken = (i == 0);
    end

    // Busy with branch held: holds, no flush, then branch taken
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_holds", int'({id_ex_hold, ex_mem_hold, if_id_flush, pc_write}), 4'b1100);
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("busy_exit_flush", if_id_flush, 1);
    chk("busy_timeout_set", mem_timeout, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    // Busy during FLUSH: remaining flush resumes afterwards
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick(); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("resume_flush_a", if_id_flush, 1);
    tick();
    @(negedge clk);
    chk("resume_flush_b", if_id_flush, 1);
    tick();
    @(negedge clk);
    chk("resume_done", if_id_flush, 0);
    tick();

    // Timeout: six busy cycles
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("timeout_busy_%0d", i), mem_timeout, (i >= 5) ? 1 : 0);
      tick();
    end
    mem_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("timeout_sticky", mem_timeout, 1);
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("timeout_cleared", mem_timeout, 0);
    tick();

    // Reset during the second FLUSH-state cycle
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    br_taken = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", ctrl_state, 0);
    chk("rst_mid_flush", if_id_flush, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_cleared", int'(stall_cycles | flush_cycles | wait_cycles), 0);
`endif
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
